// File: rtl/dma_host_bridge_if.sv
// Host-side byte streams and TPU DMA port of the host bridge, grouped as one bundle.
// master = the bridge itself; slave = the UART/TPU side that surrounds it.
`timescale 1ns/1ps
interface dma_host_bridge_if #(
    parameter int DATA_W = 256
);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              dma_start;
    logic              dma_dir;
    logic [7:0]        dma_ub_addr;
    logic [15:0]       dma_length;
    logic [1:0]        dma_elem_sz;
    logic [DATA_W-1:0] dma_data_wr;
    logic              dma_busy;
    logic              dma_done;
    logic [DATA_W-1:0] dma_data_rd;
    logic              busy;
    logic              err_pulse;

    modport master (
        input  rx_data, rx_valid, tx_ready, dma_busy, dma_done, dma_data_rd,
        output rx_ready, tx_data, tx_valid, dma_start, dma_dir, dma_ub_addr,
               dma_length, dma_elem_sz, dma_data_wr, busy, err_pulse
    );

    modport slave (
        output rx_data, rx_valid, tx_ready, dma_busy, dma_done, dma_data_rd,
        input  rx_ready, tx_data, tx_valid, dma_start, dma_dir, dma_ub_addr,
               dma_length, dma_elem_sz, dma_data_wr, busy, err_pulse
    );
endinterface

// File: rtl/dma_host_bridge.sv
// Turns framed host bytes into one-row TPU DMA commands and streams read rows,
// plus an ACK/ERR status byte, back toward the UART transmitter.
`timescale 1ns/1ps
module dma_host_bridge #(
    parameter int         DATA_W         = 256,
    parameter int         TIMEOUT_CYCLES = 65535,
    parameter logic [7:0] ACK_BYTE       = 8'h4B,
    parameter logic [7:0] ERR_BYTE       = 8'h45
) (
    input logic               clk,
    input logic               rst,
    dma_host_bridge_if.master bus
);
    localparam int             TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);

    typedef enum logic [3:0] {
        S_IDLE, S_HDR_ADDR, S_HDR_CNT, S_WR_FILL, S_WR_ISSUE, S_WR_WAIT,
        S_RD_ISSUE, S_RD_WAIT, S_RD_DRAIN, S_SEND_ACK, S_SEND_ERR
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_dir;
    logic [1:0]        r_elem_sz;
    logic [7:0]        r_addr;
    logic [7:0]        r_cnt;
    logic [4:0]        r_idx;
    logic [DATA_W-1:0] r_row;
    logic [TMO_W-1:0]  r_tmo;

    logic       w_rx_ready;
    logic       w_rx_fire;
    logic       w_tx_valid;
    logic       w_tx_fire;
    logic [7:0] w_tx_data;
    logic       w_dma_start;
    logic       w_err;
    logic       w_cmd_active;
    logic       w_wr_active;
    logic       w_tmo_hit;
    logic       w_magic_ok;

    // rx_ready is gated by rst so every output reads 0 while reset is held.
    assign w_rx_ready   = !rst && (r_state == S_IDLE || r_state == S_HDR_ADDR ||
                                   r_state == S_HDR_CNT || r_state == S_WR_FILL);
    assign w_rx_fire    = bus.rx_valid && w_rx_ready;
    assign w_tx_valid   = (r_state == S_RD_DRAIN || r_state == S_SEND_ACK ||
                           r_state == S_SEND_ERR);
    assign w_tx_fire    = w_tx_valid && bus.tx_ready;
    assign w_wr_active  = (r_state == S_WR_ISSUE || r_state == S_WR_WAIT);
    assign w_cmd_active = w_wr_active || r_state == S_RD_ISSUE || r_state == S_RD_WAIT;
    assign w_tmo_hit    = (r_tmo == TMO_LIMIT);
    assign w_magic_ok   = (bus.rx_data[7:4] == 4'hA);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        w_next      = r_state;
        w_dma_start = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            S_IDLE: if (w_rx_fire) begin
                if (!w_magic_ok) w_err  = 1'b1;
                else             w_next = S_HDR_ADDR;
            end
            S_HDR_ADDR: if (w_rx_fire) w_next = S_HDR_CNT;
            S_HDR_CNT: if (w_rx_fire) begin
                if (bus.rx_data == 8'd0) w_next = S_SEND_ACK;
                else if (r_dir)          w_next = S_RD_ISSUE;
                else                     w_next = S_WR_FILL;
            end
            S_WR_FILL: if (w_rx_fire && r_idx == 5'd31) w_next = S_WR_ISSUE;
            S_WR_ISSUE, S_RD_ISSUE: if (!bus.dma_busy) begin
                w_dma_start = 1'b1;
                w_next      = (r_state == S_WR_ISSUE) ? S_WR_WAIT : S_RD_WAIT;
            end
            // A done coincident with the start pulse lands in ISSUE and is never seen.
            S_WR_WAIT, S_RD_WAIT: begin
                if (bus.dma_done) begin
                    if (r_state == S_RD_WAIT) w_next = S_RD_DRAIN;
                    else                      w_next = (r_cnt == 8'd1) ? S_SEND_ACK : S_WR_FILL;
                end else if (w_tmo_hit) begin
                    w_err  = 1'b1;
                    w_next = S_SEND_ERR;
                end
            end
            S_RD_DRAIN: if (w_tx_fire && r_idx == 5'd31)
                w_next = (r_cnt == 8'd1) ? S_SEND_ACK : S_RD_ISSUE;
            S_SEND_ACK, S_SEND_ERR: if (w_tx_fire) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_tx_data = 8'h00;
        case (r_state)
            S_RD_DRAIN: w_tx_data = r_row[{r_idx, 3'b000} +: 8];
            S_SEND_ACK: w_tx_data = ACK_BYTE;
            S_SEND_ERR: w_tx_data = ERR_BYTE;
            default:    w_tx_data = 8'h00;
        endcase
    end

    // NOTE: the row register is reset along with the rest; it is a flop bank, not a RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dir     <= 1'b0;
            r_elem_sz <= 2'd0;
            r_addr    <= 8'd0;
            r_cnt     <= 8'd0;
            r_idx     <= 5'd0;
            r_row     <= '0;
            r_tmo     <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_rx_fire && w_magic_ok) begin
                    r_dir     <= bus.rx_data[3];
                    r_elem_sz <= bus.rx_data[1:0];
                end
                S_HDR_ADDR: if (w_rx_fire) r_addr <= bus.rx_data;
                S_HDR_CNT: if (w_rx_fire) begin
                    r_cnt <= bus.rx_data;
                    r_idx <= 5'd0;
                end
                S_WR_FILL: if (w_rx_fire) begin
                    r_row[{r_idx, 3'b000} +: 8] <= bus.rx_data;
                    r_idx <= r_idx + 5'd1;
                end
                S_WR_ISSUE, S_RD_ISSUE: if (w_dma_start) r_tmo <= '0;
                S_WR_WAIT: begin
                    if (bus.dma_done) begin
                        r_addr <= r_addr + 8'd1;
                        r_cnt  <= r_cnt - 8'd1;
                    end else if (!w_tmo_hit) begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_RD_WAIT: begin
                    if (bus.dma_done) begin
                        r_row <= bus.dma_data_rd;
                        r_idx <= 5'd0;
                    end else if (!w_tmo_hit) begin
                        r_tmo <= r_tmo + TMO_W'(1);
                    end
                end
                S_RD_DRAIN: if (w_tx_fire) begin
                    r_idx <= r_idx + 5'd1;
                    if (r_idx == 5'd31) begin
                        r_addr <= r_addr + 8'd1;
                        r_cnt  <= r_cnt - 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_ready    = w_rx_ready;
    assign bus.tx_valid    = w_tx_valid;
    assign bus.tx_data     = w_tx_data;
    assign bus.dma_start   = w_dma_start;
    assign bus.dma_dir     = w_cmd_active && r_dir;
    assign bus.dma_ub_addr = w_cmd_active ? r_addr : 8'd0;
    assign bus.dma_length  = w_cmd_active ? 16'd32 : 16'd0;
    assign bus.dma_elem_sz = w_cmd_active ? r_elem_sz : 2'd0;
    assign bus.dma_data_wr = w_wr_active ? r_row : '0;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.err_pulse   = w_err;
endmodule

// File: tb/tb_dma_host_bridge.sv
// Directed bench for dma_host_bridge: a TPU DMA responder, a tx/start/err monitor,
// and one task per scenario with hand-computed expectations.
`timescale 1ns/1ps
module tb_dma_host_bridge;
    localparam int DATA_W = 256;
    localparam int TMO    = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    dma_host_bridge_if #(.DATA_W(DATA_W)) bus ();

    dma_host_bridge #(
        .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO), .ACK_BYTE(8'h4B), .ERR_BYTE(8'h45)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    // Observations, all sampled on the falling edge.
    logic [7:0]        tx_q[$];
    logic [7:0]        cap_addr[$];
    logic              cap_dir[$];
    logic [15:0]       cap_len[$];
    logic [1:0]        cap_elem[$];
    logic [DATA_W-1:0] cap_data[$];
    int                cap_cyc[$];
    int                err_cycles = 0;
    int                stall_viol = 0;
    logic              stall_prev = 1'b0;
    logic [7:0]        stall_data = 8'h00;

    initial forever begin
        @(negedge clk);
        if (bus.tx_valid && bus.tx_ready) tx_q.push_back(bus.tx_data);
        if (stall_prev && bus.tx_valid && bus.tx_data !== stall_data) stall_viol++;
        stall_prev = bus.tx_valid && !bus.tx_ready;
        stall_data = bus.tx_data;
        if (bus.dma_start) begin
            cap_addr.push_back(bus.dma_ub_addr);
            cap_dir.push_back(bus.dma_dir);
            cap_len.push_back(bus.dma_length);
            cap_elem.push_back(bus.dma_elem_sz);
            cap_data.push_back(bus.dma_data_wr);
            cap_cyc.push_back(cyc);
        end
        if (bus.err_pulse) err_cycles++;
    end

    // tx_ready: held high, or toggled every cycle to exercise stalls.
    logic tx_toggle = 1'b0;
    initial begin
        bus.tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.tx_ready = tx_toggle ? ~bus.tx_ready : 1'b1;
        end
    end

    // TPU DMA responder: done (with read row) a fixed delay after each start.
    logic              done_en = 1'b1;
    int                done_delay = 3;
    logic [DATA_W-1:0] rd_rows[2];
    int                rd_i = 0;
    initial begin
        bus.dma_done    = 1'b0;
        bus.dma_data_rd = '0;
        forever begin
            @(negedge clk);
            if (bus.dma_start && done_en) begin
                repeat (done_delay) @(posedge clk);
                #1;
                bus.dma_data_rd = rd_rows[rd_i % 2];
                bus.dma_done    = 1'b1;
                @(posedge clk);
                #1;
                bus.dma_done = 1'b0;
                rd_i++;
            end
        end
    end

    function automatic logic [DATA_W-1:0] ramp(input logic [7:0] base);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) r[8*k +: 8] = base + 8'(k);
        return r;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (bus.rx_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL rx_accept byte %02h never accepted (rx_ready=%0b, want 1)", b, bus.rx_ready);
        end else begin
            step(1);
        end
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_write(input logic [7:0] hdr, input logic [7:0] addr, input logic [7:0] base);
        send_byte(hdr);
        send_byte(addr);
        send_byte(8'd1);
        for (int k = 0; k < 32; k++) send_byte(base + 8'(k));
    endtask

    task automatic wait_idle(input string tag);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s idle_timeout busy=%0b want 0", tag, bus.busy);
        end
        step(2);
    endtask

    task automatic clear_obs();
        tx_q.delete();
        cap_addr.delete();
        cap_dir.delete();
        cap_len.delete();
        cap_elem.delete();
        cap_data.delete();
        cap_cyc.delete();
        err_cycles = 0;
        stall_viol = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        @(negedge clk);
        checks++;
        if ({bus.rx_ready, bus.tx_valid, bus.tx_data, bus.dma_start, bus.dma_dir, bus.dma_ub_addr,
             bus.dma_length, bus.dma_elem_sz, bus.busy, bus.err_pulse} !== 40'd0) begin
            errors++;
            $display("FAIL reset_ctrl got %h want 0", {bus.rx_ready, bus.tx_valid, bus.tx_data,
                     bus.dma_start, bus.dma_dir, bus.dma_ub_addr, bus.dma_length, bus.dma_elem_sz,
                     bus.busy, bus.err_pulse});
        end
        checks++;
        if (bus.dma_data_wr !== '0) begin
            errors++;
            $display("FAIL reset_data_wr got %h want 0", bus.dma_data_wr);
        end
        step(1);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.rx_ready !== 1'b1 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release rx_ready=%0b busy=%0b want 1 0", bus.rx_ready, bus.busy);
        end
        step(1);
    endtask

    task automatic test_write();
        clear_obs();
        send_write(8'hA1, 8'h10, 8'h00);
        wait_idle("t1");
        checks++;
        if (cap_addr.size() !== 1) begin errors++; $display("FAIL t1_starts got %0d want 1", cap_addr.size()); end
        checks++;
        if (cap_dir[0] !== 1'b0) begin errors++; $display("FAIL t1_dir got %0b want 0", cap_dir[0]); end
        checks++;
        if (cap_addr[0] !== 8'h10) begin errors++; $display("FAIL t1_addr got %02h want 10", cap_addr[0]); end
        checks++;
        if (cap_len[0] !== 16'd32) begin errors++; $display("FAIL t1_len got %0d want 32", cap_len[0]); end
        checks++;
        if (cap_elem[0] !== 2'd1) begin errors++; $display("FAIL t1_elem got %0d want 1", cap_elem[0]); end
        checks++;
        if (cap_data[0][7:0] !== 8'h00 || cap_data[0][255:248] !== 8'h1F) begin
            errors++;
            $display("FAIL t1_data_ends got %02h/%02h want 00/1F", cap_data[0][7:0], cap_data[0][255:248]);
        end
        checks++;
        if (cap_data[0] !== ramp(8'h00)) begin errors++; $display("FAIL t1_data got %h want %h", cap_data[0], ramp(8'h00)); end
        checks++;
        if (tx_q.size() !== 1 || tx_q[0] !== 8'h4B) begin
            errors++;
            $display("FAIL t1_ack got n=%0d first=%02h want n=1 4B", tx_q.size(), tx_q[0]);
        end
        checks++;
        if (bus.busy !== 1'b0 || err_cycles !== 0) begin
            errors++;
            $display("FAIL t1_end busy=%0b errs=%0d want 0 0", bus.busy, err_cycles);
        end
    endtask

    task automatic test_read_stall();
        logic [7:0] exp_b;
        clear_obs();
        for (int k = 0; k < 32; k++) begin
            rd_rows[0][8*k +: 8] = 8'h80 + 8'(k);
            rd_rows[1][8*k +: 8] = 8'hFF - 8'(k);
        end
        rd_i      = 0;
        tx_toggle = 1'b1;
        send_byte(8'hA8);
        send_byte(8'hFF);
        send_byte(8'h02);
        wait_idle("t2");
        tx_toggle = 1'b0;
        checks++;
        if (cap_addr.size() !== 2) begin errors++; $display("FAIL t2_starts got %0d want 2", cap_addr.size()); end
        checks++;
        if (cap_addr[0] !== 8'hFF || cap_addr[1] !== 8'h00) begin
            errors++;
            $display("FAIL t2_addr got %02h,%02h want FF,00", cap_addr[0], cap_addr[1]);
        end
        checks++;
        if (cap_dir[0] !== 1'b1 || cap_dir[1] !== 1'b1 || cap_len[1] !== 16'd32 || cap_elem[0] !== 2'd0) begin
            errors++;
            $display("FAIL t2_cmd got dir=%0b%0b len=%0d elem=%0d want 11 32 0", cap_dir[0], cap_dir[1], cap_len[1], cap_elem[0]);
        end
        checks++;
        if (tx_q.size() !== 65) begin errors++; $display("FAIL t2_count got %0d want 65", tx_q.size()); end
        for (int i = 0; i < 64; i++) begin
            exp_b = (i < 32) ? 8'h80 + 8'(i) : 8'hFF - 8'(i - 32);
            checks++;
            if (tx_q[i] !== exp_b) begin errors++; $display("FAIL t2_byte%0d got %02h want %02h", i, tx_q[i], exp_b); end
        end
        checks++;
        if (tx_q[64] !== 8'h4B) begin errors++; $display("FAIL t2_ack got %02h want 4B", tx_q[64]); end
        checks++;
        if (stall_viol !== 0) begin errors++; $display("FAIL t2_stall_stable got %0d changes want 0", stall_viol); end
    endtask

    task automatic test_busy_holdoff();
        int drop_cyc;
        clear_obs();
        bus.dma_busy = 1'b1;
        send_write(8'hA3, 8'h20, 8'h50);
        step(10);
        checks++;
        if (cap_addr.size() !== 0) begin errors++; $display("FAIL t3_early_start got %0d want 0", cap_addr.size()); end
        bus.dma_busy = 1'b0;
        drop_cyc = cyc;
        @(negedge clk);
        checks++;
        if (bus.dma_start !== 1'b1) begin errors++; $display("FAIL t3_start_now got %0b want 1", bus.dma_start); end
        step(1);
        @(negedge clk);
        checks++;
        if (bus.dma_start !== 1'b0) begin errors++; $display("FAIL t3_start_width got %0b want 0", bus.dma_start); end
        wait_idle("t3");
        checks++;
        if (cap_addr.size() !== 1 || cap_cyc[0] !== drop_cyc) begin
            errors++;
            $display("FAIL t3_start_cycle got n=%0d cyc=%0d want n=1 cyc=%0d", cap_addr.size(), cap_cyc[0], drop_cyc);
        end
        checks++;
        if (cap_addr[0] !== 8'h20 || cap_elem[0] !== 2'd3 || cap_data[0] !== ramp(8'h50)) begin
            errors++;
            $display("FAIL t3_cmd got addr=%02h elem=%0d data=%h", cap_addr[0], cap_elem[0], cap_data[0]);
        end
        checks++;
        if (tx_q.size() !== 1 || tx_q[0] !== 8'h4B) begin
            errors++;
            $display("FAIL t3_ack got n=%0d first=%02h want n=1 4B", tx_q.size(), tx_q[0]);
        end
    endtask

    task automatic test_timeout();
        clear_obs();
        done_en = 1'b0;
        send_byte(8'hA8);
        send_byte(8'h05);
        send_byte(8'h01);
        wait_idle("t4");
        done_en = 1'b1;
        checks++;
        if (err_cycles !== 1) begin errors++; $display("FAIL t4_err_pulse got %0d want 1", err_cycles); end
        checks++;
        if (tx_q.size() !== 1 || tx_q[0] !== 8'h45) begin
            errors++;
            $display("FAIL t4_err_byte got n=%0d first=%02h want n=1 45", tx_q.size(), tx_q[0]);
        end
        checks++;
        if (cap_addr.size() !== 1) begin errors++; $display("FAIL t4_starts got %0d want 1", cap_addr.size()); end
        clear_obs();
        send_write(8'hA2, 8'h30, 8'hC0);
        wait_idle("t4b");
        checks++;
        if (cap_addr[0] !== 8'h30 || cap_elem[0] !== 2'd2 || cap_data[0] !== ramp(8'hC0)) begin
            errors++;
            $display("FAIL t4_next_cmd got addr=%02h elem=%0d data=%h", cap_addr[0], cap_elem[0], cap_data[0]);
        end
        checks++;
        if (tx_q.size() !== 1 || tx_q[0] !== 8'h4B || err_cycles !== 0) begin
            errors++;
            $display("FAIL t4_next_ack got n=%0d first=%02h errs=%0d want n=1 4B 0", tx_q.size(), tx_q[0], err_cycles);
        end
    endtask

    task automatic test_bad_magic_zero();
        clear_obs();
        send_byte(8'h5A);
        step(2);
        checks++;
        if (err_cycles !== 1 || bus.busy !== 1'b0 || cap_addr.size() !== 0) begin
            errors++;
            $display("FAIL t5_magic got errs=%0d busy=%0b starts=%0d want 1 0 0", err_cycles, bus.busy, cap_addr.size());
        end
        send_byte(8'hA0);
        send_byte(8'h00);
        send_byte(8'h00);
        wait_idle("t5");
        checks++;
        if (tx_q.size() !== 1 || tx_q[0] !== 8'h4B) begin
            errors++;
            $display("FAIL t5_zero_ack got n=%0d first=%02h want n=1 4B", tx_q.size(), tx_q[0]);
        end
        checks++;
        if (cap_addr.size() !== 0 || err_cycles !== 1) begin
            errors++;
            $display("FAIL t5_zero_quiet got starts=%0d errs=%0d want 0 1", cap_addr.size(), err_cycles);
        end
    endtask

    task automatic test_reset_mid_write();
        clear_obs();
        send_byte(8'hA1);
        send_byte(8'h40);
        send_byte(8'h01);
        for (int k = 0; k < 7; k++) send_byte(8'(k));
        rst = 1'b1;
        step(1);
        @(negedge clk);
        checks++;
        if ({bus.rx_ready, bus.tx_valid, bus.tx_data, bus.dma_start, bus.dma_dir, bus.dma_ub_addr,
             bus.dma_length, bus.dma_elem_sz, bus.busy, bus.err_pulse} !== 40'd0) begin
            errors++;
            $display("FAIL t6_reset_ctrl got %h want 0", {bus.rx_ready, bus.tx_valid, bus.tx_data,
                     bus.dma_start, bus.dma_dir, bus.dma_ub_addr, bus.dma_length, bus.dma_elem_sz,
                     bus.busy, bus.err_pulse});
        end
        checks++;
        if (bus.dma_data_wr !== '0) begin errors++; $display("FAIL t6_reset_data got %h want 0", bus.dma_data_wr); end
        step(2);
        rst = 1'b0;
        step(5);
        checks++;
        if (tx_q.size() !== 0 || cap_addr.size() !== 0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL t6_silent got tx=%0d starts=%0d busy=%0b want 0 0 0", tx_q.size(), cap_addr.size(), bus.busy);
        end
        send_write(8'hA1, 8'h40, 8'h33);
        wait_idle("t6");
        checks++;
        if (cap_addr.size() !== 1 || cap_addr[0] !== 8'h40 || cap_data[0] !== ramp(8'h33)) begin
            errors++;
            $display("FAIL t6_after got n=%0d addr=%02h data=%h", cap_addr.size(), cap_addr[0], cap_data[0]);
        end
        checks++;
        if (tx_q.size() !== 1 || tx_q[0] !== 8'h4B) begin
            errors++;
            $display("FAIL t6_ack got n=%0d first=%02h want n=1 4B", tx_q.size(), tx_q[0]);
        end
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.dma_busy = 1'b0;
        test_reset();
        test_write();
        test_read_stall();
        test_busy_holdoff();
        test_timeout();
        test_bad_magic_zero();
        test_reset_mid_write();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/dma_host_bridge.md
Name: dma_host_bridge

Overview:
Host-side initiator for the tpu_top DMA port. It turns a framed byte stream (from the UART receive path) into DMA commands and row transfers, and returns read data plus status bytes on a byte stream toward the UART transmitter. It drives dma_start_in/dir/ub_addr/length/elem_sz/data_in and consumes dma_busy_out/done_out/data_out. Every DMA command moves exactly one 256-bit Unified Buffer row.

Parameters:
DATA_W, 256, DMA row width in bits; fixed at 32 bytes per row.
TIMEOUT_CYCLES, 65535, maximum cycles to wait for dma_done after a start pulse.
ACK_BYTE, 8'h4B, status byte sent on success.
ERR_BYTE, 8'h45, status byte sent on timeout.

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
rx_data  in  8  inbound byte
rx_valid  in  1  inbound byte valid
rx_ready  out  1  bridge accepts a byte when rx_valid && rx_ready
tx_data  out  8  outbound byte
tx_valid  out  1  outbound byte valid
tx_ready  in  1  downstream accepts when tx_valid && tx_ready
dma_start  out  1  one-cycle command pulse
dma_dir  out  1  0 = host to UB (write), 1 = UB to host (read)
dma_ub_addr  out  8  UB row address
dma_length  out  16  bytes per command; always 16'd32 while a command is active
dma_elem_sz  out  2  element size code, passed through from the header
dma_data_wr  out  DATA_W  write row data
dma_busy  in  1  TPU DMA engine busy
dma_done  in  1  TPU DMA completion pulse
dma_data_rd  in  DATA_W  read row data, valid in the dma_done cycle
busy  out  1  high in any state other than IDLE
err_pulse  out  1  one-cycle pulse on bad magic or timeout

Behaviour:
- Reset: while rst=1 at a clock edge, all outputs go to 0 (rx_ready, tx_valid, dma_* and busy included) and state goes to IDLE. Reset mid-transfer abandons the command silently: no ACK or ERR byte is sent.
- Frame format:
  - byte0: [7:4] = 4'hA magic, [3] = dir, [2] reserved (ignored), [1:0] = elem_sz.
  - byte1: start UB address.
  - byte2: row count N.
  - Write frames then carry N×32 payload bytes. Payload byte k of a row maps to data[8k+7:8k] (little-endian).
- rx_ready = 1 only in IDLE, HDR_ADDR, HDR_CNT and WR_FILL.
- States and transitions:
  - IDLE: on an accepted byte with magic ≠ 4'hA, drop it, pulse err_pulse, stay in IDLE. Otherwise latch dir and elem_sz, go to HDR_ADDR.
  - HDR_ADDR: latch the address, go to HDR_CNT.
  - HDR_CNT: latch N. If N = 0, go to SEND_ACK. Otherwise go to WR_FILL (dir = 0) or RD_ISSUE (dir = 1).
  - WR_FILL: a 5-bit byte index fills a row register. After byte 31 is accepted, go to WR_ISSUE.
  - WR_ISSUE / RD_ISSUE: wait while dma_busy = 1. On the first cycle with dma_busy = 0, assert dma_start for exactly one cycle, then go to WR_WAIT / RD_WAIT.
  - Hold stable from the start pulse until done: dma_dir, dma_ub_addr, dma_length = 32, dma_elem_sz, dma_data_wr.
  - WR_WAIT / RD_WAIT: dma_done is sampled starting the cycle after the start pulse. A done asserted in the same cycle as start is ignored. A timeout counter clears on start; when it reaches TIMEOUT_CYCLES with no done, pulse err_pulse and go to SEND_ERR.
  - WR_WAIT on done: increment address (mod 256) and decrement the remaining count. If the remaining count is 0, go to SEND_ACK; otherwise go to WR_FILL.
  - RD_WAIT on done: capture dma_data_rd into the row register, go to RD_DRAIN.
  - RD_DRAIN: present bytes 0..31 in order on tx. Advance only on tx_valid && tx_ready; tx_data stays stable while stalled. After byte 31, update address and count as in write; then go to SEND_ACK if the count is 0, else RD_ISSUE.
  - SEND_ACK / SEND_ERR: present ACK_BYTE / ERR_BYTE until accepted, then go to IDLE.
- Address wrap: 8'hFF + 1 → 8'h00 with no error.
- dma_length and dma_data_wr are 0 in IDLE.
- tx_valid drops the cycle after the final accepted byte unless another byte is pending.

Test Plan:
1. Write: bytes A1,10,01 then 32 bytes 00..1F → one dma_start, dir=0, addr=0x10, len=32, elem_sz=1, dma_data_wr[7:0]=00 and [255:248]=1F; done → tx 4B; busy returns to 0.
2. Read with tx stalls: bytes A8,FF,02, dma_done 3 cycles after each start, dma_data_rd rows R0, R1; tx_ready toggled 1/0 → addresses FF then 00; 64 bytes out in order with no drops or duplicates; then 4B.
3. Busy hold-off: dma_busy=1 for 10 cycles when entering an ISSUE state → dma_start asserts on the first cycle busy=0 and is exactly 1 cycle wide.
4. Timeout: TIMEOUT_CYCLES=16, read command, dma_done never asserted → err_pulse once, tx 45, return to IDLE, next valid frame processed normally.
5. Bad magic and N=0: byte 5A → err_pulse, no DMA activity. Then A0,00,00 → tx 4B, no dma_start.
6. Reset mid-write after 7 payload bytes → all outputs 0, no ACK or ERR byte. A subsequent full frame completes correctly.
